// File: rtl/hps_upload_pkg.sv
// Shared definitions for the HPS upload responder: FSM states and the byte
// returned for reads that fall outside the backing memory.
package hps_upload_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PAUSE = 2'd1,
        READY = 2'd2,
        FETCH = 2'd3
    } state_t;

    localparam logic [7:0] OOR_BYTE = 8'hFF;

endpackage

// File: rtl/hiscore_upload.sv
// Streams bytes from a core-side RAM to the HPS during an upload session,
// holding the CPU paused so the memory contents stay stable.
module hiscore_upload
    import hps_upload_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int MEM_SIZE = 1024,
    parameter int RD_LAT   = 1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              upload_sel,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              pause_req,
    input  logic              pause_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [7:0]        ram_q,
    output logic              busy
);

    localparam int CNT_W = 2;

    state_t             state, state_nxt;
    logic [7:0]         din_nxt;
    logic               wait_nxt, pause_nxt, rd_nxt;
    logic [ADDR_W-1:0]  raddr_nxt;
    logic               pend, pend_nxt;
    logic [24:0]        pend_addr, paddr_nxt;
    logic               oor, oor_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               lost, lost_nxt;
    logic               start;
    logic [24:0]        start_addr;

    // High address bits must be clear as well as the address being below MEM_SIZE.
    function automatic logic in_range(input logic [24:0] a);
        logic [24:0] lim;
        lim = 25'(MEM_SIZE);
        return (a[24:ADDR_W] == '0) && (a < lim);
    endfunction

    assign busy = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        din_nxt    = ioctl_din;
        wait_nxt   = ioctl_wait;
        pause_nxt  = pause_req;
        rd_nxt     = 1'b0;
        raddr_nxt  = ram_addr;
        pend_nxt   = pend;
        paddr_nxt  = pend_addr;
        oor_nxt    = oor;
        cnt_nxt    = cnt;
        lost_nxt   = lost;
        start      = 1'b0;
        start_addr = ioctl_addr;

        case (state)
            IDLE: begin
                if (upload_sel) begin
                    state_nxt = PAUSE;
                    pause_nxt = 1'b1;
                    pend_nxt  = 1'b0;
                end
            end
            PAUSE: begin
                // Only the first early read is held; the HPS is stalled after it.
                if (ioctl_rd && !pend) begin
                    pend_nxt  = 1'b1;
                    paddr_nxt = ioctl_addr;
                    wait_nxt  = 1'b1;
                end
                if (pause_ack) state_nxt = READY;
            end
            READY: begin
                if (!pause_ack) begin
                    state_nxt = PAUSE;
                    if (ioctl_rd && !pend) begin
                        pend_nxt  = 1'b1;
                        paddr_nxt = ioctl_addr;
                        wait_nxt  = 1'b1;
                    end
                end else if (pend || ioctl_rd) begin
                    start      = 1'b1;
                    start_addr = pend ? pend_addr : ioctl_addr;
                end
            end
            FETCH: begin
                if (!pause_ack) lost_nxt = 1'b1;
                if (cnt == '0) begin
                    din_nxt   = oor ? OOR_BYTE : ram_q;
                    wait_nxt  = 1'b0;
                    state_nxt = (lost || !pause_ack) ? PAUSE : READY;
                    lost_nxt  = 1'b0;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (start) begin
            state_nxt = FETCH;
            wait_nxt  = 1'b1;
            pend_nxt  = 1'b0;
            lost_nxt  = 1'b0;
            cnt_nxt   = CNT_W'(RD_LAT - 1);
            oor_nxt   = !in_range(start_addr);
            if (in_range(start_addr)) begin
                rd_nxt    = 1'b1;
                raddr_nxt = start_addr[ADDR_W-1:0];
            end
        end

        // Dropping the select ends the session from any active state.
        if (state != IDLE && !upload_sel) begin
            state_nxt = IDLE;
            pause_nxt = 1'b0;
            wait_nxt  = 1'b0;
            rd_nxt    = 1'b0;
            pend_nxt  = 1'b0;
            lost_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            ioctl_din  <= 8'h00;
            ioctl_wait <= 1'b0;
            pause_req  <= 1'b0;
            ram_addr   <= '0;
            ram_rd     <= 1'b0;
            pend       <= 1'b0;
            cnt        <= '0;
            lost       <= 1'b0;
        end else begin
            state      <= state_nxt;
            ioctl_din  <= din_nxt;
            ioctl_wait <= wait_nxt;
            pause_req  <= pause_nxt;
            ram_addr   <= raddr_nxt;
            ram_rd     <= rd_nxt;
            pend       <= pend_nxt;
            cnt        <= cnt_nxt;
            lost       <= lost_nxt;
        end
    end

    always_ff @(posedge clk_sys) begin
        pend_addr <= paddr_nxt;
        oor       <= oor_nxt;
    end

endmodule

// File: tb/tb_hiscore_upload.sv
// Bench for hiscore_upload: two instances (RAM latency 1 and 3) driven
// from vector tables, randomized reads and hand-written session sequences.
module tb_hiscore_upload;

    localparam int MEM_SIZE = 1024;

    logic       clk = 1'b0;
    logic       reset;
    logic       sel   [2];
    logic       rd    [2];
    logic [24:0] addr [2];
    logic       ack   [2];
    logic [7:0] din   [2];
    logic       wt    [2];
    logic       preq  [2];
    logic [9:0] raddr [2];
    logic       rrd   [2];
    logic       bsy   [2];
    logic [7:0] q0, q1, s1, s2;
    logic [7:0] mem [0:MEM_SIZE-1];
    int         nrd [2];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hiscore_upload #(.ADDR_W(10), .MEM_SIZE(MEM_SIZE), .RD_LAT(1)) u_lat1 (
        .clk_sys(clk), .reset(reset), .upload_sel(sel[0]), .ioctl_rd(rd[0]),
        .ioctl_addr(addr[0]), .ioctl_din(din[0]), .ioctl_wait(wt[0]),
        .pause_req(preq[0]), .pause_ack(ack[0]), .ram_addr(raddr[0]),
        .ram_rd(rrd[0]), .ram_q(q0), .busy(bsy[0]));

    hiscore_upload #(.ADDR_W(10), .MEM_SIZE(MEM_SIZE), .RD_LAT(3)) u_lat3 (
        .clk_sys(clk), .reset(reset), .upload_sel(sel[1]), .ioctl_rd(rd[1]),
        .ioctl_addr(addr[1]), .ioctl_din(din[1]), .ioctl_wait(wt[1]),
        .pause_req(preq[1]), .pause_ack(ack[1]), .ram_addr(raddr[1]),
        .ram_rd(rrd[1]), .ram_q(q1), .busy(bsy[1]));

    // RAM models: data for the held address is presented in the last
    // cycle of the latency window.
    assign q0 = mem[raddr[0]];
    always @(posedge clk) begin
        s1 <= mem[raddr[1]];
        s2 <= s1;
    end
    assign q1 = s2;

    initial begin
        nrd[0] = 0;
        nrd[1] = 0;
    end
    always @(posedge clk) begin
        if (rrd[0]) nrd[0] <= nrd[0] + 1;
        if (rrd[1]) nrd[1] <= nrd[1] + 1;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [24:0] a);
        if (a < 25'(MEM_SIZE)) return mem[a[9:0]];
        return 8'hFF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input int i);
        chk("rst_din",   32'(din[i]),   32'h00);
        chk("rst_wait",  32'(wt[i]),    32'd0);
        chk("rst_preq",  32'(preq[i]),  32'd0);
        chk("rst_raddr", 32'(raddr[i]), 32'd0);
        chk("rst_ramrd", 32'(rrd[i]),   32'd0);
        chk("rst_busy",  32'(bsy[i]),   32'd0);
    endtask

    task automatic open_session(input int i, input int dly);
        sel[i] = 1'b1;
        ack[i] = 1'b0;
        @(negedge clk);
        chk("open_preq", 32'(preq[i]), 32'd1);
        chk("open_busy", 32'(bsy[i]), 32'd1);
        repeat (dly) @(negedge clk);
        ack[i] = 1'b1;
        @(negedge clk);
    endtask

    task automatic close_session(input int i);
        sel[i] = 1'b0;
        ack[i] = 1'b0;
        @(negedge clk);
        chk("close_preq", 32'(preq[i]), 32'd0);
        chk("close_busy", 32'(bsy[i]), 32'd0);
    endtask

    // Strobe in READY at cycle N, then follow the transaction to N+1+latency.
    task automatic do_read(input int i, input logic [24:0] a, input logic [7:0] e,
                           input bit erd, input bit noise);
        int L;
        int d0;
        L = lat_of(i);
        d0 = nrd[i];
        rd[i] = 1'b1;
        addr[i] = a;
        @(negedge clk);
        rd[i] = 1'b0;
        for (int k = 1; k <= L; k++) begin
            chk("fetch_wait", 32'(wt[i]), 32'd1);
            chk("fetch_ramrd", 32'(rrd[i]), (k == 1) ? 32'(erd) : 32'd0);
            if (k == 1 && erd) chk("fetch_raddr", 32'(raddr[i]), 32'(a[9:0]));
            if (noise) begin
                rd[i] = 1'($urandom_range(0, 1));
                addr[i] = 25'($urandom);
            end
            @(negedge clk);
            rd[i] = 1'b0;
        end
        chk("done_wait", 32'(wt[i]), 32'd0);
        chk("done_din", 32'(din[i]), 32'(e));
        chk("ramrd_count", 32'(nrd[i] - d0), 32'(erd));
        @(negedge clk);
        chk("no_requeue", 32'(wt[i]), 32'd0);
    endtask

    typedef struct {
        int          inst;
        logic [24:0] a;
        bit          wr;
        logic [7:0]  wdata;
        logic [7:0]  exp_din;
        bit          exp_rd;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int d0;
        int cyc;
        logic [24:0] ra;
        logic [7:0] prev;

        tbl[0] = '{0, 25'd5,        1'b1, 8'h3C, 8'h3C, 1'b1};
        tbl[1] = '{0, 25'd1023,     1'b1, 8'hA5, 8'hA5, 1'b1};
        tbl[2] = '{0, 25'd1024,     1'b0, 8'h00, 8'hFF, 1'b0};
        tbl[3] = '{0, 25'h100005,   1'b0, 8'h00, 8'hFF, 1'b0};
        tbl[4] = '{0, 25'd0,        1'b1, 8'h00, 8'h00, 1'b1};
        tbl[5] = '{1, 25'd0,        1'b1, 8'h11, 8'h11, 1'b1};
        tbl[6] = '{1, 25'd1024,     1'b0, 8'h00, 8'hFF, 1'b0};
        tbl[7] = '{1, 25'h1FFFFFF,  1'b0, 8'h00, 8'hFF, 1'b0};
        tbl[8] = '{1, 25'd512,      1'b1, 8'h5A, 8'h5A, 1'b1};
        tbl[9] = '{1, 25'd1023,     1'b1, 8'hE7, 8'hE7, 1'b1};

        for (int k = 0; k < MEM_SIZE; k++) mem[k] = 8'($urandom);
        for (int i = 0; i < 2; i++) begin
            sel[i] = 1'b0; rd[i] = 1'b0; ack[i] = 1'b0; addr[i] = '0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_vals(0);
        chk_reset_vals(1);
        reset = 1'b0;
        @(negedge clk);

        open_session(0, 4);
        open_session(1, 2);

        for (int v = 0; v < 10; v++) begin
            if (tbl[v].wr) mem[tbl[v].a[9:0]] = tbl[v].wdata;
            do_read(tbl[v].inst, tbl[v].a, tbl[v].exp_din, tbl[v].exp_rd, 1'b0);
        end

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 3))
                0: ra = 25'($urandom_range(0, MEM_SIZE - 1));
                1: ra = 25'($urandom_range(MEM_SIZE, MEM_SIZE + 100));
                2: ra = 25'($urandom);
                default: ra = 25'(MEM_SIZE - 1);
            endcase
            do_read(0, ra, ref_byte(ra), ra < 25'(MEM_SIZE), n[0]);
        end

        for (int a = 0; a < MEM_SIZE; a++)
            do_read(1, 25'(a), ref_byte(25'(a)), 1'b1, a[0]);

        // Pause lost during a fetch: the fetch finishes, the next read waits for ack.
        d0 = nrd[1];
        rd[1] = 1'b1; addr[1] = 25'd20;
        @(negedge clk);
        rd[1] = 1'b0; ack[1] = 1'b0;
        chk("ploss_wait", 32'(wt[1]), 32'd1);
        repeat (3) @(negedge clk);
        chk("ploss_done_wait", 32'(wt[1]), 32'd0);
        chk("ploss_din", 32'(din[1]), 32'(ref_byte(25'd20)));
        chk("ploss_preq", 32'(preq[1]), 32'd1);
        rd[1] = 1'b1; addr[1] = 25'd21;
        @(negedge clk);
        rd[1] = 1'b0;
        chk("ploss_hold_wait", 32'(wt[1]), 32'd1);
        repeat (3) @(negedge clk);
        chk("ploss_hold_rd", 32'(nrd[1] - d0), 32'd1);
        ack[1] = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (wt[1] && cyc < 20);
        chk("ploss_timeout", 32'(wt[1]), 32'd0);
        chk("ploss_din2", 32'(din[1]), 32'(ref_byte(25'd21)));
        chk("ploss_rd_total", 32'(nrd[1] - d0), 32'd2);

        // Early read issued while still waiting for the pause acknowledge.
        close_session(0);
        mem[7] = 8'hC3;
        sel[0] = 1'b1;
        @(negedge clk);
        d0 = nrd[0];
        rd[0] = 1'b1; addr[0] = 25'd7;
        @(negedge clk);
        rd[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("early_wait", 32'(wt[0]), 32'd1);
            @(negedge clk);
        end
        chk("early_no_rd", 32'(nrd[0] - d0), 32'd0);
        ack[0] = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (wt[0] && cyc < 20);
        chk("early_timeout", 32'(wt[0]), 32'd0);
        chk("early_din", 32'(din[0]), 32'h0C3);
        chk("early_rd_count", 32'(nrd[0] - d0), 32'd1);

        // Abort in the middle of a fetch, then start a fresh session.
        prev = din[1];
        rd[1] = 1'b1; addr[1] = 25'd30;
        @(negedge clk);
        rd[1] = 1'b0; sel[1] = 1'b0;
        chk("abort_fetch_wait", 32'(wt[1]), 32'd1);
        @(negedge clk);
        chk("abort_preq", 32'(preq[1]), 32'd0);
        chk("abort_wait", 32'(wt[1]), 32'd0);
        chk("abort_ramrd", 32'(rrd[1]), 32'd0);
        chk("abort_busy", 32'(bsy[1]), 32'd0);
        chk("abort_din_kept", 32'(din[1]), 32'(prev));
        ack[1] = 1'b0;
        repeat (2) @(negedge clk);
        open_session(1, 3);
        do_read(1, 25'd31, ref_byte(25'd31), 1'b1, 1'b0);

        // Reset while a session is live.
        chk("pre_reset_preq", 32'(preq[0]), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals(0);
        chk_reset_vals(1);
        reset = 1'b0;
        sel[0] = 1'b0; sel[1] = 1'b0; ack[0] = 1'b0; ack[1] = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
